// File: rtl/led_pattern_gen.sv
// LED pattern generator: a rate-selectable step timer drives a rotate/bounce/binary
// pattern machine. Switch inputs are resynchronised to clk_in before use.
module led_pattern_gen #(
  parameter int N_LED     = 4,
  parameter int CNT_W     = 23,
  parameter int STEP_CNT0 = 1_000_000,
  parameter int STEP_CNT1 = 1_750_000,
  parameter int STEP_CNT2 = 2_500_000,
  parameter int STEP_CNT3 = 5_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [1:0]       rate,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] LIM0     = CNT_W'(STEP_CNT0 - 1);
  localparam logic [CNT_W-1:0] LIM1     = CNT_W'(STEP_CNT1 - 1);
  localparam logic [CNT_W-1:0] LIM2     = CNT_W'(STEP_CNT2 - 1);
  localparam logic [CNT_W-1:0] LIM3     = CNT_W'(STEP_CNT3 - 1);
  localparam logic [N_LED-1:0] LED_INIT = N_LED'(1);

  logic [1:0]       r_rateMeta, r_rateSync, r_rateQ;
  logic [1:0]       r_modeMeta, r_modeSync, r_modeQ;
  logic             r_pauseMeta, r_pauseSync;
  logic [CNT_W-1:0] r_cnt, w_cntNext, w_limitM1;
  logic [N_LED-1:0] r_led, w_ledNext, w_ledStep;
  dir_t             r_dir, w_dirNext, w_dirStep;
  logic             r_step, w_stepNext;
  logic             w_modeChange, w_rateChange, w_tick;
  mode_t            w_mode;

  // Two-flop synchronisers plus a previous-value stage for change detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_rateMeta  <= '0;
      r_rateSync  <= '0;
      r_rateQ     <= '0;
      r_modeMeta  <= '0;
      r_modeSync  <= '0;
      r_modeQ     <= '0;
      r_pauseMeta <= 1'b0;
      r_pauseSync <= 1'b0;
    end else begin
      r_rateMeta  <= rate;
      r_rateSync  <= r_rateMeta;
      r_rateQ     <= r_rateSync;
      r_modeMeta  <= mode;
      r_modeSync  <= r_modeMeta;
      r_modeQ     <= r_modeSync;
      r_pauseMeta <= pause;
      r_pauseSync <= r_pauseMeta;
    end
  end

  assign w_mode       = mode_t'(r_modeSync);
  assign w_modeChange = (r_modeSync != r_modeQ);
  assign w_rateChange = (r_rateSync != r_rateQ);
  assign w_tick       = (r_cnt == w_limitM1);

  always_comb begin
    w_limitM1 = LIM0;
    case (r_rateSync)
      2'b00:   w_limitM1 = LIM0;
      2'b01:   w_limitM1 = LIM1;
      2'b10:   w_limitM1 = LIM2;
      default: w_limitM1 = LIM3;
    endcase
  end

  // State register: pattern, bounce direction, step timer and strobe.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_led  <= LED_INIT;
      r_dir  <= DIR_UP;
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      r_led  <= w_ledNext;
      r_dir  <= w_dirNext;
      r_cnt  <= w_cntNext;
      r_step <= w_stepNext;
    end
  end

  // Bounce turns around on the step that leaves an end bit, so each end is lit once.
  always_comb begin
    w_ledStep = r_led;
    w_dirStep = r_dir;
    case (w_mode)
      MODE_ROL: w_ledStep = {r_led[N_LED-2:0], r_led[N_LED-1]};
      MODE_ROR: w_ledStep = {r_led[0], r_led[N_LED-1:1]};
      MODE_BOUNCE: begin
        if (r_dir == DIR_UP) begin
          if (r_led[N_LED-1]) begin
            w_ledStep = r_led >> 1;
            w_dirStep = DIR_DOWN;
          end else begin
            w_ledStep = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_ledStep = r_led << 1;
            w_dirStep = DIR_UP;
          end else begin
            w_ledStep = r_led >> 1;
          end
        end
      end
      MODE_COUNT: w_ledStep = r_led + LED_INIT;
      default: w_ledStep = r_led;
    endcase
  end

  always_comb begin
    w_ledNext  = r_led;
    w_dirNext  = r_dir;
    w_cntNext  = r_cnt;
    w_stepNext = 1'b0;
    if (w_modeChange) begin
      w_ledNext = LED_INIT;
      w_dirNext = DIR_UP;
      w_cntNext = '0;
    end else if (w_rateChange) begin
      w_cntNext = '0;
    end else if (r_pauseSync) begin
      w_cntNext = r_cnt;
    end else if (w_tick) begin
      w_ledNext  = w_ledStep;
      w_dirNext  = w_dirStep;
      w_cntNext  = '0;
      w_stepNext = 1'b1;
    end else begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  always_comb begin
    led  = r_led;
    step = r_step;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for the board's LED bank. It combines a rate-selectable step timer with a pattern state machine in one block, and runs directly from the divided system clock. It supersedes the fixed 4-LED shift/divider pair. It adds:
- configurable LED count and step periods
- bounce and binary-count modes
- pause
- a step strobe

Parameters:
- N_LED, 4, number of LEDs driven; legal range is 2..16.
- CNT_W, 23, width of the step counter; it must hold STEP_CNT3-1.
- STEP_CNT0, 1_000_000, clk_in cycles per step when rate=00 (200 ms at 5 MHz).
- STEP_CNT1, 1_750_000, clk_in cycles per step when rate=01 (350 ms).
- STEP_CNT2, 2_500_000, clk_in cycles per step when rate=10 (500 ms).
- STEP_CNT3, 5_000_000, clk_in cycles per step when rate=11 (1 s).

Ports:
- clk_in, input, 1, block clock (5 MHz on board).
- rst, input, 1, reset; asynchronous, active-high.
- rate, input, 2, step-period select from the switches; asynchronous to clk_in.
- mode, input, 2, pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count; asynchronous.
- pause, input, 1, freezes pattern and timer while high; asynchronous.
- led, output, N_LED, LED drive; bit 0 is the rightmost LED.
- step, output, 1, one-cycle strobe, high in the cycle led takes a new pattern value.

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, including mid-step. Reset values:
  - led = 1 (only bit 0 lit)
  - step = 0
  - counter = 0
  - direction = up
  - all synchroniser and previous-value registers = 0
- Input synchronisation:
  - rate, mode and pause each pass through a 2-flop synchroniser, giving rate_s, mode_s and pause_s.
  - rate_q and mode_q hold the previous-cycle values of rate_s and mode_s.
  - A change on an input pin acts at the 3rd rising clk_in edge after it (2 edges of synchroniser, 1 edge of change detection).
- Step timer:
  - Limit L = STEP_CNT[rate_s].
  - Each edge the counter increments. When counter == L-1, a tick fires and the counter returns to 0.
  - The first step after reset therefore lands on the L-th edge.
- Priority per edge, highest first:
  1. Mode change (mode_s != mode_q): led = 1, direction = up, counter = 0, step = 0. Any tick due in the same cycle is dropped. A simultaneous rate change is absorbed here.
  2. Rate change (rate_s != rate_q): counter = 0, step = 0, led holds. A due tick is dropped.
  3. pause_s = 1: counter and led hold, step = 0. When pause falls, counting resumes from the held count, not from 0.
  4. Tick: led advances one pattern step and step = 1 for that cycle only.
  5. Otherwise the counter increments and step = 0.
- Pattern step rules:
  - Rotate-left (00): led <= {led[N-2:0], led[N-1]}.
  - Rotate-right (01): led <= {led[0], led[N-1:1]}.
  - Bounce (10): a single lit bit walks toward the MSB while direction = up.
    - On the step leaving bit N-1, it moves to bit N-2 and direction becomes down.
    - Symmetrically, on the step leaving bit 0, it moves to bit 1 and direction becomes up.
    - Each end LED is lit for exactly one step. No LED is ever dark for a step, and no bit is lit twice in a row.
    - N_LED=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, and so on.
  - Binary count (11): led <= led + 1, modulo 2^N_LED. All-ones wraps to all-zeros; all-zeros is a legal displayed state.
- Rotate modes preserve whatever pattern is present. After a mode change that pattern is always the single bit 0.
- led and step are registered outputs with no combinational path from inputs.

Test Plan:
All scenarios use N_LED=4, STEP_CNT0..3 = 4, 6, 8, 10, and inputs held stable before reset release unless stated.

1. Reset, then mode=00, rate=00 -> led=0001 until edge 4. Then 0010, 0100, 1000, 0001 at edges 4, 8, 12, 16, with step high exactly on those 4 cycles.
2. Mode=10 for 12 steps -> led follows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100, 1000, 0100, 0010. Mode=11 for 17 steps from reload -> led goes 0001 through 1111, then 0000, then 0001.
3. In mode=01 with led=0100, switch rate 00->11 in the cycle before a due tick -> no step. led stays 0100 for 10 further edges after the detected change, then becomes 0010.
4. Change mode 00->10 while counter=3 (tick due) -> at the 3rd edge after the pin change: led=0001, step=0, counter=0. The next step is 4 edges later, giving led=0010.
5. Assert pause with counter=2 for 20 cycles -> led and step frozen. After release (plus sync latency) the tick arrives after 1 further counting edge.
6. Assert rst asynchronously between edges while led=1000 with step high -> led=0001 and step=0 immediately, without waiting for a clk_in edge. After release the sequence restarts as in scenario 1.
